// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and region helpers for the sync generator and character generator.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int TICK_DIV_DEFAULT     = 4;
    localparam int BLINK_FRAMES_DEFAULT = 30;

    typedef logic [COORD_W-1:0] coord_t;

    // Levels as seen on the pins: syncs are active-low, video_on active-high.
    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_RESET = '{video_on: 1'b1, hsync: 1'b1, vsync: 1'b1};

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic sync_t sync_levels(
        input coord_t x,
        input coord_t y,
        input coord_t h_vis,
        input coord_t v_vis,
        input coord_t hs_start,
        input coord_t hs_end,
        input coord_t vs_start,
        input coord_t vs_end
    );
        sync_t s;
        s.video_on = (x < h_vis) && (y < v_vis);
        s.hsync    = !in_range(x, hs_start, hs_end);
        s.vsync    = !in_range(y, vs_start, vs_end);
        return s;
    endfunction

endpackage

// File: rtl/blink_divider.sv
// Cursor blink divider: toggles parpadeo every BLINK_FRAMES frame_tick pulses.
// Latency: parpadeo changes on the clk edge after the completing frame_tick.
// Backpressure: none; frame_tick is a free-running strobe.
module blink_divider #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic parpadeo
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            parpadeo  <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                parpadeo  <= ~parpadeo;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel strobe, pixel coordinates, registered hsync/vsync/video_on, frame tick, blink (VGA_BLINK_EN).
// Latency: all outputs are flops; sync/video_on change on the same clk edge as pixel_x/pixel_y.
// Backpressure: none; free-running timing source.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int HD           = H_DISPLAY,
    parameter int HFP          = H_FRONT,
    parameter int HSW          = H_SYNC,
    parameter int HBP          = H_BACK,
    parameter int VD           = V_DISPLAY,
    parameter int VFP          = V_FRONT,
    parameter int VSW          = V_SYNC,
    parameter int VBP          = V_BACK,
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    output logic         p_tick,
    output logic [9:0]   pixel_x,
    output logic [9:0]   pixel_y,
    output logic         video_on,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_tick,
    output logic         parpadeo
);

    localparam int H_TOT = HD + HFP + HSW + HBP;
    localparam int V_TOT = VD + VFP + VSW + VBP;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(HD);
    localparam coord_t V_VIS    = coord_t'(VD);
    localparam coord_t HS_START = coord_t'(HD + HFP);
    localparam coord_t HS_END   = coord_t'(HD + HFP + HSW - 1);
    localparam coord_t VS_START = coord_t'(VD + VFP);
    localparam coord_t VS_END   = coord_t'(VD + VFP + VSW - 1);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    coord_t           x_d;
    coord_t           y_d;
    logic             x_wrap;
    logic             y_wrap;
    logic             frame_d;
    sync_t            sync_q;

    // p_tick is registered from the next divider value, so it is high exactly while div_q == DIV_LAST.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_wrap  = (pixel_x == H_LAST);
        y_wrap  = (pixel_y == V_LAST);
        x_d     = pixel_x;
        y_d     = pixel_y;
        frame_d = 1'b0;
        if (p_tick) begin
            x_d = x_wrap ? '0 : pixel_x + 1'b1;
            if (x_wrap) begin
                y_d = y_wrap ? '0 : pixel_y + 1'b1;
            end
            frame_d = x_wrap && y_wrap;
        end
    end

    // Sync levels come from the next-state coordinates so every output moves on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            p_tick     <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            sync_q     <= SYNC_RESET;
            frame_tick <= 1'b0;
        end else begin
            div_q      <= div_d;
            p_tick     <= (div_d == DIV_LAST);
            pixel_x    <= x_d;
            pixel_y    <= y_d;
            sync_q     <= sync_levels(x_d, y_d, H_VIS, V_VIS, HS_START, HS_END, VS_START, VS_END);
            frame_tick <= frame_d;
        end
    end

    assign video_on = sync_q.video_on;
    assign hsync    = sync_q.hsync;
    assign vsync    = sync_q.vsync;

`ifdef VGA_BLINK_EN
    blink_divider #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_divider (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .parpadeo   (parpadeo)
    );
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign parpadeo         = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced raster so whole frames fit in a short run.
// Expected outputs are derived arithmetically from the clk count since reset release.
module tb_vga_sync_gen;

    localparam int HD  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VD  = 4;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int TD  = 4;
    localparam int BF  = 3;
    localparam int HT  = HD + HFP + HSW + HBP;
    localparam int VT  = VD + VFP + VSW + VBP;
    localparam int N_CYC = 8000;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_tick;
        logic       parpadeo;
    } obs_t;

    typedef struct packed {
        logic rst;
        obs_t o;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
    logic       parpadeo;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_frames = 0;
    int   dut_frames = 0;
    rec_t exp_q[$];

    always #5 clk = ~clk;

    vga_sync_gen #(
        .HD(HD), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VD(VD), .VFP(VFP), .VSW(VSW), .VBP(VBP),
        .TICK_DIV(TD), .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick),
        .parpadeo   (parpadeo)
    );

    // k = clk edges since reset release; every output follows from k by plain arithmetic.
    function automatic obs_t model(input int k);
        obs_t o;
        int   pix, x, y, frames_done;
        pix = k / TD;
        x   = pix % HT;
        y   = (pix / HT) % VT;
        o.p_tick     = (k % TD) == (TD - 1);
        o.x          = 10'(x);
        o.y          = 10'(y);
        o.video_on   = (x < HD) && (y < VD);
        o.hsync      = !((x >= HD + HFP) && (x < HD + HFP + HSW));
        o.vsync      = !((y >= VD + VFP) && (y < VD + VFP + VSW));
        o.frame_tick = (k > 0) && (k % TD == 0) && (pix % (HT * VT) == 0);
        frames_done  = (k >= 1) ? (k - 1) / (TD * HT * VT) : 0;
`ifdef VGA_BLINK_EN
        o.parpadeo   = ((frames_done / BF) % 2) == 1;
`else
        o.parpadeo   = 1'b0;
        if (frames_done < 0) o.parpadeo = 1'b1;
`endif
        return o;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: one DUT observation per clk, compared against the head of the scoreboard.
    initial begin
        rec_t e;
        obs_t got;
        int   h_run, v_run;
        h_run = 0;
        v_run = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick, parpadeo};
                n_tests++;
                if (got !== e.o) begin
                    n_fail++;
                    if (n_fail < 20)
                        $display("FAIL outputs rst=%0b: got x=%0d y=%0d bits=%h, expected x=%0d y=%0d bits=%h",
                                 e.rst, got.x, got.y, got, e.o.x, e.o.y, e.o);
                end
                if (frame_tick === 1'b1) dut_frames++;
                if (e.rst) begin
                    h_run = 0;
                    v_run = 0;
                end else begin
                    if (hsync === 1'b0) h_run++;
                    else if (h_run > 0) begin
                        check("hsync_low_clks", h_run, HSW * TD);
                        h_run = 0;
                    end
                    if (vsync === 1'b0) v_run++;
                    else if (v_run > 0) begin
                        check("vsync_low_clks", v_run, VSW * HT * TD);
                        v_run = 0;
                    end
                end
            end
        end
    end

    // Stimulus: reset sequencing (one fixed mid-frame hit plus random late hits) and expected pushes.
    initial begin
        int   k, hold;
        rec_t r;
        reset = 1'b1;
        hold  = 3;
        k     = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            if (!reset) k++;
            if (reset) begin
                hold--;
                if (hold <= 0) reset = 1'b0;
            end else if (cyc == 300 || (cyc > 5000 && cyc < 7000 && $urandom_range(0, 799) == 0)) begin
                reset = 1'b1;
                hold  = (cyc == 300) ? 3 : int'($urandom_range(1, 4));
                k     = 0;
            end
            r.rst = reset;
            r.o   = model(k);
            if (r.o.frame_tick) exp_frames++;
            exp_q.push_back(r);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_tick_count", dut_frames, exp_frames);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
